// File: rtl/reg_exec_seq_pkg.sv
// Shared definitions for the execute sequencer: widths, opcode map, FSM encoding
// and opcode classification helpers.
package exec_pkg;

    localparam int EXEC_DATA_W = 32'sd8;
    localparam int EXEC_ADDR_W = 32'sd4;
    localparam int OPC_W       = 32'sd4;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_MOV = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_NOP = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    function automatic logic is_write_op(input logic [3:0] op);
        return (op <= OP_MOV);
    endfunction

    // Z/N/C are only touched by arithmetic/logic ops and CMP; LDI/MOV/NOP/illegal hold them.
    function automatic logic is_flag_op(input logic [3:0] op);
        return (op <= OP_SHR) || (op == OP_CMP);
    endfunction

    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op >= 4'hB) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/reg_exec_seq_if.sv
// Instruction handshake plus register-bank port bundle. The master side is the
// instruction source / bank owner, the slave side is the sequencer.
interface reg_exec_seq_if
    import exec_pkg::*;
#(
    parameter int DATA_W = EXEC_DATA_W,
    parameter int ADDR_W = EXEC_ADDR_W
);
    logic              instr_valid;
    logic              instr_ready;
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] imm;
    logic              rb_w_r;
    logic [ADDR_W-1:0] rb_w_add;
    logic [ADDR_W-1:0] rb_r_add_1;
    logic [ADDR_W-1:0] rb_r_add_2;
    logic [DATA_W-1:0] rb_data;
    logic [DATA_W-1:0] rb_data_1;
    logic [DATA_W-1:0] rb_data_2;
    logic              flag_z;
    logic              flag_c;
    logic              flag_n;
    logic              done;
    logic              illegal;

    modport master (
        output instr_valid, opcode, rd, rs1, rs2, imm, rb_data_1, rb_data_2,
        input  instr_ready, rb_w_r, rb_w_add, rb_r_add_1, rb_r_add_2, rb_data,
        input  flag_z, flag_c, flag_n, done, illegal
    );

    modport slave (
        input  instr_valid, opcode, rd, rs1, rs2, imm, rb_data_1, rb_data_2,
        output instr_ready, rb_w_r, rb_w_add, rb_r_add_1, rb_r_add_2, rb_data,
        output flag_z, flag_c, flag_n, done, illegal
    );

endinterface

// File: rtl/reg_exec_seq_alu_core.sv
// Purely combinational ALU: result, carry/borrow and write/illegal classification
// for one opcode applied to the latched operands.
module alu_core
    import exec_pkg::*;
#(
    parameter int DW = EXEC_DATA_W
) (
    input  logic [OPC_W-1:0] i_opcode,
    input  logic [DW-1:0]    i_a,
    input  logic [DW-1:0]    i_b,
    input  logic [DW-1:0]    i_imm,
    output logic [DW-1:0]    o_result,
    output logic             o_c_out,
    output logic             o_wr_en,
    output logic             o_illegal
);

    logic [DW:0] w_sum;

    // Opcode decode; SUB/CMP share the borrow path so CMP sets flags exactly like SUB.
    always_comb begin
        w_sum    = '0;
        o_result = '0;
        o_c_out  = 1'b0;
        case (i_opcode)
            OP_ADD: begin
                w_sum    = {1'b0, i_a} + {1'b0, i_b};
                o_result = w_sum[DW-1:0];
                o_c_out  = w_sum[DW];
            end
            OP_SUB, OP_CMP: begin
                w_sum    = {1'b0, i_a} - {1'b0, i_b};
                o_result = w_sum[DW-1:0];
                o_c_out  = w_sum[DW];
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_NOT:  o_result = ~i_a;
            OP_SHL: begin
                o_result = {i_a[DW-2:0], 1'b0};
                o_c_out  = i_a[DW-1];
            end
            OP_SHR: begin
                o_result = {1'b0, i_a[DW-1:1]};
                o_c_out  = i_a[0];
            end
            OP_LDI:  o_result = i_imm;
            OP_MOV:  o_result = i_a;
            default: o_result = '0;
        endcase
    end

    assign o_wr_en   = is_write_op(i_opcode);
    assign o_illegal = is_illegal_op(i_opcode);

endmodule

// File: rtl/reg_exec_seq.sv
// Multi-cycle execute sequencer: IDLE -> READ -> EXEC -> WB, owning all timing of
// the combinational-read register bank and issuing a single write-back strobe.
module reg_exec_seq
    import exec_pkg::*;
#(
    parameter int DATA_W = EXEC_DATA_W,
    parameter int ADDR_W = EXEC_ADDR_W
) (
    input logic           clk,
    input logic           rst,
    reg_exec_seq_if.slave bus
);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_accept;

    logic [OPC_W-1:0]  r_opcode;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;

    logic              r_ready;
    logic              r_rb_w_r;
    logic [ADDR_W-1:0] r_rb_w_add;
    logic [ADDR_W-1:0] r_rb_r_add_1;
    logic [ADDR_W-1:0] r_rb_r_add_2;
    logic [DATA_W-1:0] r_rb_data;
    logic              r_flag_z;
    logic              r_flag_c;
    logic              r_flag_n;
    logic              r_done;
    logic              r_illegal;

    logic [DATA_W-1:0] w_result;
    logic              w_c_out;
    logic              w_wr_en;
    logic              w_illegal;

    alu_core #(.DW(DATA_W)) u_alu (
        .i_opcode  (r_opcode),
        .i_a       (r_op_a),
        .i_b       (r_op_b),
        .i_imm     (r_imm),
        .o_result  (w_result),
        .o_c_out   (w_c_out),
        .o_wr_en   (w_wr_en),
        .o_illegal (w_illegal)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; only IDLE can wait, every other state lasts one cycle.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    w_next_state = S_READ;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_READ:  w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_WB;
            S_WB:    w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; strobes are set on the EXEC->WB edge so they
    // are high for exactly the WB cycle, and a reset in EXEC abandons them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opcode     <= '0;
            r_rd         <= '0;
            r_imm        <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_ready      <= 1'b1;
            r_rb_w_r     <= 1'b0;
            r_rb_w_add   <= '0;
            r_rb_r_add_1 <= '0;
            r_rb_r_add_2 <= '0;
            r_rb_data    <= '0;
            r_flag_z     <= 1'b0;
            r_flag_c     <= 1'b0;
            r_flag_n     <= 1'b0;
            r_done       <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_ready   <= (w_next_state == S_IDLE);
            r_rb_w_r  <= (r_state == S_EXEC) && w_wr_en;
            r_done    <= (r_state == S_EXEC);
            r_illegal <= (r_state == S_EXEC) && w_illegal;
            if (w_accept) begin
                r_opcode     <= bus.opcode;
                r_rd         <= bus.rd;
                r_imm        <= bus.imm;
                r_rb_r_add_1 <= bus.rs1;
                r_rb_r_add_2 <= bus.rs2;
            end
            // Operands are captured before write-back, so rd may alias a source.
            if (r_state == S_READ) begin
                r_op_a <= bus.rb_data_1;
                r_op_b <= bus.rb_data_2;
            end
            if (r_state == S_EXEC) begin
                if (w_wr_en) begin
                    r_rb_w_add <= r_rd;
                    r_rb_data  <= w_result;
                end
                if (is_flag_op(r_opcode)) begin
                    r_flag_z <= (w_result == '0);
                    r_flag_n <= w_result[DATA_W-1];
                    r_flag_c <= w_c_out;
                end
            end
        end
    end

    assign bus.instr_ready = r_ready;
    assign bus.rb_w_r      = r_rb_w_r;
    assign bus.rb_w_add    = r_rb_w_add;
    assign bus.rb_r_add_1  = r_rb_r_add_1;
    assign bus.rb_r_add_2  = r_rb_r_add_2;
    assign bus.rb_data     = r_rb_data;
    assign bus.flag_z      = r_flag_z;
    assign bus.flag_c      = r_flag_c;
    assign bus.flag_n      = r_flag_n;
    assign bus.done        = r_done;
    assign bus.illegal     = r_illegal;

endmodule

// File: tb/tb_reg_exec_seq.sv
// Directed bench for reg_exec_seq with a behavioural 16x8 register bank and a
// scoreboard of expected retirements built from an independent instruction model.
module tb_reg_exec_seq;

    typedef struct {
        logic       wr;
        logic [3:0] addr;
        logic [7:0] data;
        logic       z;
        logic       c;
        logic       n;
        logic       ill;
    } exp_t;

    logic clk;
    logic rst;
    logic bank_clr;
    logic [7:0] bank [16];

    logic [7:0] m_bank [16];
    logic       mz, mc, mn;
    exp_t       sb [$];

    int checks = 0;
    int errors = 0;

    reg_exec_seq_if bus ();

    reg_exec_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank: combinational reads, write on the clock edge while strobed.
    always @(posedge clk) begin
        if (bank_clr) begin
            for (int i = 0; i < 16; i++) bank[i] <= 8'h00;
        end else if (bus.rb_w_r) begin
            bank[bus.rb_w_add] <= bus.rb_data;
        end
    end
    assign bus.rb_data_1 = bank[bus.rb_r_add_1];
    assign bus.rb_data_2 = bank[bus.rb_r_add_2];

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bank(input string tag);
        for (int i = 0; i < 16; i++) chk(tag, {4'(i), 4'h0, bank[i]}, {4'(i), 4'h0, m_bank[i]});
    endtask

    // Model the instruction, push its expected retirement, then drive and check it.
    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [7:0] imm);
        exp_t e;
        exp_t got;
        int a, b, r, cyc;
        logic c;
        a = int'(m_bank[rs1]);
        b = int'(m_bank[rs2]);
        c = mc;
        r = 0;
        case (op)
            4'h0: begin r = a + b; c = (r > 255); end
            4'h1, 4'hA: begin r = a - b; c = (a < b); end
            4'h2: begin r = a & b; c = 1'b0; end
            4'h3: begin r = a | b; c = 1'b0; end
            4'h4: begin r = a ^ b; c = 1'b0; end
            4'h5: begin r = 255 - a; c = 1'b0; end
            4'h6: begin r = a * 2; c = (a >= 128); end
            4'h7: begin r = a / 2; c = (a % 2 == 1); end
            4'h8: r = int'(imm);
            4'h9: r = a;
            default: r = 0;
        endcase
        r = r & 255;
        if (op <= 4'h7 || op == 4'hA) begin
            mz = (r == 0);
            mn = (r >= 128);
            mc = c;
        end
        e.wr   = (op <= 4'h9);
        e.ill  = (op >= 4'hB) && (op <= 4'hE);
        e.addr = rd;
        e.data = r[7:0];
        e.z = mz; e.c = mc; e.n = mn;
        if (e.wr) m_bank[rd] = r[7:0];
        sb.push_back(e);

        @(negedge clk);
        chk("ready_idle", {15'h0, bus.instr_ready}, 16'h1);
        bus.instr_valid = 1'b1;
        bus.opcode = op; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.opcode = 4'($urandom); bus.rd = 4'($urandom);
        bus.rs1 = 4'($urandom); bus.rs2 = 4'($urandom); bus.imm = 8'($urandom);
        cyc = 1;
        while (!bus.done && cyc < 8) begin
            chk("busy_no_wr", {15'h0, bus.rb_w_r}, 16'h0);
            chk("busy_ready", {15'h0, bus.instr_ready}, 16'h0);
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 16'(cyc), 16'd3);
        got = sb.pop_front();
        chk("wb_strobe", {15'h0, bus.rb_w_r}, {15'h0, got.wr});
        if (got.wr) begin
            chk("wb_addr", {12'h0, bus.rb_w_add}, {12'h0, got.addr});
            chk("wb_data", {8'h0, bus.rb_data}, {8'h0, got.data});
        end
        chk("flags", {13'h0, bus.flag_z, bus.flag_c, bus.flag_n}, {13'h0, got.z, got.c, got.n});
        chk("illegal", {15'h0, bus.illegal}, {15'h0, got.ill});
        @(posedge clk);
        #1;
        chk("post_strobe", {15'h0, bus.rb_w_r}, 16'h0);
        chk("post_done", {15'h0, bus.done}, 16'h0);
        chk("post_illegal", {15'h0, bus.illegal}, 16'h0);
        chk_bank("bank");
    endtask

    initial begin
        rst = 1'b1;
        bank_clr = 1'b1;
        bus.instr_valid = 1'b0;
        bus.opcode = 4'h0; bus.rd = 4'h0; bus.rs1 = 4'h0; bus.rs2 = 4'h0; bus.imm = 8'h00;
        for (int i = 0; i < 16; i++) m_bank[i] = 8'h00;
        mz = 1'b0; mc = 1'b0; mn = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {15'h0, bus.instr_ready}, 16'h1);
        chk("rst_strobe", {15'h0, bus.rb_w_r}, 16'h0);
        chk("rst_done", {14'h0, bus.done, bus.illegal}, 16'h0);
        chk("rst_flags", {13'h0, bus.flag_z, bus.flag_c, bus.flag_n}, 16'h0);
        chk("rst_addr", {4'h0, bus.rb_w_add, bus.rb_r_add_1, bus.rb_r_add_2}, 16'h0);
        chk("rst_data", {8'h0, bus.rb_data}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        bank_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_done", {15'h0, bus.done}, 16'h0);

        issue(4'h8, 4'd3, 4'd0, 4'd0, 8'h7F);
        issue(4'h8, 4'd4, 4'd0, 4'd0, 8'h01);
        issue(4'h0, 4'd5, 4'd3, 4'd4, 8'h00);
        chk("add_r5", {8'h0, bank[5]}, 16'h0080);
        chk("add_flags", {13'h0, bus.flag_z, bus.flag_c, bus.flag_n}, 16'h1);

        issue(4'h8, 4'd1, 4'd0, 4'd0, 8'h05);
        issue(4'h1, 4'd2, 4'd1, 4'd3, 8'h00);
        chk("sub_r2", {8'h0, bank[2]}, 16'h0086);
        chk("sub_flags", {13'h0, bus.flag_z, bus.flag_c, bus.flag_n}, 16'h3);
        issue(4'hA, 4'd1, 4'd1, 4'd1, 8'h00);
        chk("cmp_r1", {8'h0, bank[1]}, 16'h0005);
        chk("cmp_flags", {13'h0, bus.flag_z, bus.flag_c, bus.flag_n}, 16'h4);

        issue(4'h8, 4'd6, 4'd0, 4'd0, 8'h81);
        issue(4'h6, 4'd6, 4'd6, 4'd0, 8'h00);
        chk("shl_r6", {8'h0, bank[6]}, 16'h0002);
        chk("shl_c", {15'h0, bus.flag_c}, 16'h1);
        issue(4'h7, 4'd6, 4'd6, 4'd0, 8'h00);
        chk("shr_r6", {8'h0, bank[6]}, 16'h0001);
        chk("shr_c", {15'h0, bus.flag_c}, 16'h0);

        issue(4'h2, 4'd8, 4'd3, 4'd5, 8'h00);
        issue(4'h3, 4'd9, 4'd3, 4'd5, 8'h00);
        issue(4'h4, 4'd10, 4'd3, 4'd9, 8'h00);
        issue(4'h5, 4'd11, 4'd5, 4'd0, 8'h00);
        issue(4'h9, 4'd12, 4'd2, 4'd0, 8'h00);

        issue(4'hC, 4'd5, 4'd1, 4'd2, 8'h00);
        issue(4'hF, 4'd5, 4'd1, 4'd2, 8'h00);
        chk("nop_r5", {8'h0, bank[5]}, 16'h0080);

        // Abandon an ADD into r7 by resetting during its EXEC cycle.
        issue(4'h8, 4'd7, 4'd0, 4'd0, 8'h11);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.opcode = 4'h0; bus.rd = 4'd7; bus.rs1 = 4'd3; bus.rs2 = 4'd4;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_strobe", {15'h0, bus.rb_w_r}, 16'h0);
        chk("rstmid_done", {15'h0, bus.done}, 16'h0);
        chk("rstmid_ready", {15'h0, bus.instr_ready}, 16'h1);
        @(negedge clk);
        rst = 1'b0;
        mz = 1'b0; mc = 1'b0; mn = 1'b0;
        @(posedge clk);
        #1;
        chk("rstmid_r7", {8'h0, bank[7]}, 16'h0011);
        chk("rstmid_idle_done", {15'h0, bus.done}, 16'h0);
        issue(4'h0, 4'd7, 4'd3, 4'd4, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
